alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Command-side controller for the 5-bit combinational ALU.
- Accepts operation requests over a valid/ready command channel and drives the ALU opcode and operand inputs in a fixed, glitch-safe sequence.
- Captures the ALU result and carry, and returns them over a valid/ready response channel.
- Keeps an accumulator, so chained operations can use the previous result as operand A.

Parameters:
- WIDTH, 5, data width of operands, result and accumulator.
- OPW, 4, opcode width.
- PARK_OP, 4'hF, opcode driven on alu_S while no operation is in flight (the ALU's undefined-op code).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  OPW  opcode: 0 add, 1 sub, 2 shl, 3 shr, 4 rol, 5 ror, 6 and, 7 or, 8 xor, 9 nor, 10 nand, 11 xnor, 12 gt, 13 lt, 14 eq, 15 illegal
- cmd_a  input  WIDTH  operand A (ignored when cmd_use_acc=1)
- cmd_b  input  WIDTH  operand B
- cmd_use_acc  input  1  take operand A from the accumulator
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_y  output  WIDTH  captured result
- rsp_cout  output  1  captured carry (meaningful for op 0 and op 2 only; forced 0 otherwise)
- rsp_err  output  1  illegal opcode
- acc  output  WIDTH  accumulator value
- alu_S  output  OPW  opcode to the ALU
- alu_A  output  WIDTH  operand A to the ALU
- alu_B  output  WIDTH  operand B to the ALU
- alu_Y  input  WIDTH  ALU result
- alu_Cout  input  1  ALU carry

Behaviour:
- Reset (asynchronous, any state): state=IDLE; cmd_ready=1; rsp_valid=0; rsp_y=0; rsp_cout=0; rsp_err=0; acc=0; alu_S=PARK_OP; alu_A=0; alu_B=0.
- Why the fixed sequence: the ALU re-evaluates only when its opcode input changes. Operands are therefore always stable before the opcode moves away from PARK_OP.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch op and B, and latch A as (cmd_use_acc ? acc : cmd_a). Then go to SETUP, or to RESP with err=1 if op==15.
  - SETUP: drive alu_A and alu_B from the latches; alu_S=PARK_OP. Go to EXEC.
  - EXEC: alu_S=op. Go to CAPTURE.
  - CAPTURE: register rsp_y=alu_Y, and rsp_cout=alu_Cout if op is 0 or 2, else 0; rsp_err=0. acc<=alu_Y. alu_S<=PARK_OP. Go to RESP.
  - RESP: rsp_valid=1, with rsp_y, rsp_cout and rsp_err held stable. On rsp_ready, return to IDLE and drop rsp_valid.
- cmd_ready is 1 only in IDLE; there is no queueing. Accept-to-rsp_valid latency is 4 cycles for legal ops and 1 cycle for an illegal op.
- Illegal op: rsp_y=0, rsp_cout=0, rsp_err=1. acc is unchanged and the ALU is not exercised.
- Compare ops (12–14): result is 0 or 1 in bit 0 and upper bits are 0. The sequencer passes alu_Y through unmodified.
- Width rules: all values are WIDTH bits. Sub wraps modulo 2^WIDTH. Carry comes only from the ALU.
- Backpressure: rsp_valid stays asserted and data stays stable indefinitely while rsp_ready=0. cmd_valid is ignored outside IDLE.
- Handshake timing: rsp_ready and cmd_valid in the same cycle in RESP does not accept the command. The command is accepted in the following IDLE cycle (minimum 1 bubble).
- Reset mid-operation: the in-flight op is discarded with no response, acc=0, and alu_S returns to PARK_OP immediately.
- cmd_use_acc with acc never written uses acc=0.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants OP_ADD through OP_EQ and OP_ILLEGAL=4'hF;
  - the WIDTH and OPW constants;
  - the state enum IDLE/SETUP/EXEC/CAPTURE/RESP.
- The ALU is instantiated beside alu_sequencer at the top level, not inside it.
- No sub-module inside alu_sequencer; the FSM and datapath registers are one block.

Test Plan:
- Add with carry: op=0, a=20, b=15 -> rsp_valid 4 cycles after accept; rsp_y=3, rsp_cout=1, rsp_err=0, acc=3.
- Sub wrap: op=1, a=3, b=5 -> rsp_y=30, rsp_cout=0.
- Accumulator chain: op=0, a=1, b=2 (rsp_y=3), then op=2 with use_acc=1 and cmd_a=31 -> rsp_y=6, rsp_cout=0, acc=6.
- Illegal op: op=15, a=7, b=7 -> rsp_valid 1 cycle after accept; rsp_err=1, rsp_y=0; acc unchanged; alu_S stays 4'hF throughout.
- Backpressure: op=6, a=5'b10110, b=5'b01110, with rsp_ready=0 for 10 cycles -> rsp_y=5'b00110 held stable and cmd_ready=0 the whole time. Releasing rsp_ready gives IDLE the next cycle.
- Reset mid-op: assert rst during EXEC of op=0, 9+9 -> no rsp_valid; all outputs at reset values in the same cycle; the next command completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and sequencer state encoding
package alu_pkg;
   localparam int WIDTH = 5;
   localparam int OPW   = 4;

   localparam logic [OPW-1:0] OP_ADD     = 4'h0;
   localparam logic [OPW-1:0] OP_SUB     = 4'h1;
   localparam logic [OPW-1:0] OP_SHL     = 4'h2;
   localparam logic [OPW-1:0] OP_SHR     = 4'h3;
   localparam logic [OPW-1:0] OP_ROL     = 4'h4;
   localparam logic [OPW-1:0] OP_ROR     = 4'h5;
   localparam logic [OPW-1:0] OP_AND     = 4'h6;
   localparam logic [OPW-1:0] OP_OR      = 4'h7;
   localparam logic [OPW-1:0] OP_XOR     = 4'h8;
   localparam logic [OPW-1:0] OP_NOR     = 4'h9;
   localparam logic [OPW-1:0] OP_NAND    = 4'hA;
   localparam logic [OPW-1:0] OP_XNOR    = 4'hB;
   localparam logic [OPW-1:0] OP_GT      = 4'hC;
   localparam logic [OPW-1:0] OP_LT      = 4'hD;
   localparam logic [OPW-1:0] OP_EQ      = 4'hE;
   localparam logic [OPW-1:0] OP_ILLEGAL = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EXEC,
      CAPTURE,
      RESP
   } state_t;

   // Only add and shift-left produce a carry worth reporting.
   function automatic logic has_carry(input logic [OPW-1:0] op);
      return (op == OP_ADD) || (op == OP_SHL);
   endfunction
endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - drives an external combinational ALU with operands settled
// before the opcode leaves the park code, and returns result/carry over valid/ready.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int                 WIDTH   = alu_pkg::WIDTH,
   parameter int                 OPW     = alu_pkg::OPW,
   parameter logic [OPW-1:0]     PARK_OP = 4'hF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPW-1:0]   cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_use_acc,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_cout,
   output logic             rsp_err,
   output logic [WIDTH-1:0] acc,
   output logic [OPW-1:0]   alu_S,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   input  logic [WIDTH-1:0] alu_Y,
   input  logic             alu_Cout
);

   state_t           state;
   logic [OPW-1:0]   op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_cout  <= 1'b0;
         rsp_err   <= 1'b0;
         acc       <= '0;
         alu_S     <= PARK_OP;
         alu_A     <= '0;
         alu_B     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  b_q       <= cmd_b;
                  a_q       <= cmd_use_acc ? acc : cmd_a;
                  cmd_ready <= 1'b0;
                  // Illegal ops answer straight away; the ALU never sees them.
                  if (cmd_op == OP_ILLEGAL) begin
                     rsp_y     <= '0;
                     rsp_cout  <= 1'b0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     state <= SETUP;
                  end
               end
            end
            SETUP: begin
               alu_A <= a_q;
               alu_B <= b_q;
               alu_S <= PARK_OP;
               state <= EXEC;
            end
            EXEC: begin
               alu_S <= op_q;
               state <= CAPTURE;
            end
            CAPTURE: begin
               rsp_y     <= alu_Y;
               rsp_cout  <= has_carry(op_q) ? alu_Cout : 1'b0;
               rsp_err   <= 1'b0;
               acc       <= alu_Y;
               alu_S     <= PARK_OP;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               rsp_valid <= 1'b0;
               alu_S     <= PARK_OP;
            end
         endcase
      end
   end

endmodule
